// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   WIDTH_MIN/WIDTH_MAX, width_ok() : legal operand-width range and its check
package seq_shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_rca_adder.sv
// Ripple-carry adder built from a chain of full_adder cells.
//   full_adder : a_i, b_i, c_i -> s_o (sum), c_o (carry)
//   rca_adder  : a_i[WIDTH], b_i[WIDTH] -> sum_o[WIDTH], cout_o (carry out of the MSB)
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module rca_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;
  assign cout_o   = carry[WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[gi]),
      .b_i (b_i[gi]),
      .c_i (carry[gi]),
      .s_o (sum_o[gi]),
      .c_o (carry[gi+1])
    );
  end
endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial
// product per clock. Operands are accepted in IDLE, WIDTH steps run in RUN, and
// the product is presented in DONE until the consumer takes it.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   in_m, in_q          : multiplicand, multiplier
//   in_sgn              : two's-complement mode (only with MULT_SIGNED_EN)
//   out_valid/out_ready : product handshake
//   out_p               : product; holds the last result until reset
//   busy                : high while stepping (RUN)
// Build option: define MULT_SIGNED_EN to add the in_sgn port and sign handling.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_q,
`ifdef MULT_SIGNED_EN
  input  logic               in_sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("seq_shift_add_mult: WIDTH must be in 2..32");
  end

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  // The accumulator's top bit is always zero after the shift, so only the
  // low WIDTH bits are stored; the adder's carry-out supplies S[WIDTH].
  logic [WIDTH-1:0]     a_q, a_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum_lo;
  logic                 sum_co;
  logic [WIDTH:0]       sum_full;
  logic [2*WIDTH-1:0]   prod_raw;

  assign addend   = q_q[0] ? m_q : '0;
  assign sum_full = {sum_co, sum_lo};
  // {A,Q} after the final shift: this is the unsigned product.
  assign prod_raw = {sum_full[WIDTH:1], sum_full[0], q_q[WIDTH-1:1]};

  rca_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a_q),
    .b_i    (addend),
    .sum_o  (sum_lo),
    .cout_o (sum_co)
  );

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      count_q <= '0;
      p_q     <= '0;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      count_q <= count_d;
      p_q     <= p_d;
`ifdef MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    count_d = count_q;
    p_d     = p_q;
`ifdef MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          a_d     = '0;
          count_d = '0;
`ifdef MULT_SIGNED_EN
          // Signed operands are stepped as magnitudes; the most negative
          // value maps onto its unsigned bit pattern, which is its magnitude.
          sign_d = in_sgn & (in_m[WIDTH-1] ^ in_q[WIDTH-1]);
          m_d    = (in_sgn && in_m[WIDTH-1]) ? WIDTH'(-in_m) : in_m;
          q_d    = (in_sgn && in_q[WIDTH-1]) ? WIDTH'(-in_q) : in_q;
`else
          m_d = in_m;
          q_d = in_q;
`endif
        end
      end
      ST_RUN: begin
        a_d     = sum_full[WIDTH:1];
        q_d     = {sum_full[0], q_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
`ifdef MULT_SIGNED_EN
          p_d = sign_q ? (2*WIDTH)'(-prod_raw) : prod_raw;
`else
          p_d = prod_raw;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign out_p     = p_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_m;
  logic [W-1:0] in_q;
`ifdef MULT_SIGNED_EN
  logic         in_sgn;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] out_p;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_q      (in_q),
`ifdef MULT_SIGNED_EN
    .in_sgn    (in_sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    bit             sgn;
    int             hold;
    logic [2*W-1:0] exp_p;
  } vec_t;

  vec_t vecs[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands' numeric values.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                                             input bit sgn);
    int mi, qi;
    if (sgn) begin
      mi = int'($signed(m));
      qi = int'($signed(q));
    end else begin
      mi = int'({24'd0, m});
      qi = int'({24'd0, q});
    end
    return (2*W)'(mi * qi);
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                        input bit sgn, input int hold, input logic [2*W-1:0] exp);
    int guard;
    int lat;
    bit ctl_bad;
    bit stable_bad;
    logic [2*W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin tick; guard++; end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_m     = m;
    in_q     = q;
`ifdef MULT_SIGNED_EN
    in_sgn   = sgn;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick;
    in_valid = 1'b0;
    lat = 0;
    ctl_bad = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready || !busy) ctl_bad = 1'b1;
      tick;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(W));
    check({tag, ".run_ctl"}, 32'(ctl_bad), 32'd0);
    check({tag, ".out_p"}, 32'(out_p), 32'(exp));
    held = out_p;
    stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (!out_valid || out_p !== held) stable_bad = 1'b1;
    end
    if (hold > 0) check({tag, ".held"}, 32'(stable_bad), 32'd0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, ".drop"}, 32'(out_valid), 32'd0);
    check({tag, ".keep_p"}, 32'(out_p), 32'(exp));
    $display("op %s: m=0x%02h q=0x%02h sgn=%0d hold=%0d -> p=0x%04h (lat %0d)",
             tag, m, q, sgn, hold, out_p, lat);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_m      = '0;
    in_q      = '0;
    out_ready = 1'b0;
`ifdef MULT_SIGNED_EN
    in_sgn    = 1'b0;
`endif
    tick;
    tick;
    rst = 1'b0;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.out_p", 32'(out_p), 32'd0);
    $display("reset: in_ready=%0d out_valid=%0d busy=%0d out_p=0x%04h", in_ready, out_valid, busy, out_p);

    vecs.push_back('{m: 8'hFF, q: 8'hFF, sgn: 1'b0, hold: 0, exp_p: 16'hFE01});
    vecs.push_back('{m: 8'h00, q: 8'h5A, sgn: 1'b0, hold: 0, exp_p: 16'h0000});
    vecs.push_back('{m: 8'h01, q: 8'hC3, sgn: 1'b0, hold: 1, exp_p: 16'h00C3});
    vecs.push_back('{m: 8'd13, q: 8'd11, sgn: 1'b0, hold: 5, exp_p: 16'h008F});
    vecs.push_back('{m: 8'h80, q: 8'h02, sgn: 1'b0, hold: 0, exp_p: 16'h0100});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{m: 8'hFD, q: 8'h05, sgn: 1'b1, hold: 0, exp_p: 16'hFFF1});
    vecs.push_back('{m: 8'h80, q: 8'h80, sgn: 1'b1, hold: 2, exp_p: 16'h4000});
    vecs.push_back('{m: 8'hFD, q: 8'h05, sgn: 1'b0, hold: 0, exp_p: 16'h04F1});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].sgn, vecs[i].hold, vecs[i].exp_p);

    // Reset at step 4 of 0x7F*0x02 discards the operation.
    in_m = 8'h7F; in_q = 8'h02; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.out_p", 32'(out_p), 32'd0);
    $display("op midrst: reset at step 4 -> in_ready=%0d out_valid=%0d out_p=0x%04h", in_ready, out_valid, out_p);
    run_op("after_rst", 8'h03, 8'h03, 1'b0, 0, 16'h0009);

    // in_valid held through RUN and DONE: second operand ignored until IDLE.
    in_m = 8'h02; in_q = 8'h03; in_valid = 1'b1;
    tick;
    in_m = 8'h11; in_q = 8'h11;
    lat = 0;
    while (!out_valid && lat < 50) begin tick; lat++; end
    check("ign.latency", 32'(lat), 32'(W));
    check("ign.out_p", 32'(out_p), 32'h0006);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("b2b.idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b.idle_busy", 32'(busy), 32'd0);
    tick;
    in_valid = 1'b0;
    check("b2b.accept_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin tick; lat++; end
    check("b2b.latency", 32'(lat), 32'(W));
    check("b2b.out_p", 32'(out_p), 32'h0121);
    $display("op b2b: 2*3 then 0x11*0x11 -> p=0x%04h (lat %0d)", out_p, lat);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Randomised operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] rm, rq;
      bit rs;
      rm = W'($urandom);
      rq = W'($urandom);
`ifdef MULT_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rnd%0d", i), rm, rq, rs, int'($urandom_range(0, 3)), ref_mul(rm, rq, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
